// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared state type and default constants for the motion sequencer
// Purpose: state encoding of the sequencer FSM, default parameter values and a
//          small helper used when sizing counters.
// Ports:   none (package).
package robot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    TURN   = 2'd2,
    SETTLE = 2'd3
  } motion_state_t;

  localparam int STEP_DIV_DEF   = 4;
  localparam int FWD_STEPS_DEF  = 8;
  localparam int TURN_STEPS_DEF = 4;
  localparam int SETTLE_CYC_DEF = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - wheel step rate prescaler
// Purpose: counts 0..STEP_DIV-1 while enabled and flags the terminal count.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  restart the count at 0 on the next edge
//   enable   in  advance the count
//   tick     out count is at STEP_DIV-1 (a step happens in this cycle)
//   pre_tick out count is at STEP_DIV-2 (a step happens in the next cycle)
module step_prescaler
  import robot_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic pre_tick
);

  localparam int PW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PRE  = PW'(STEP_DIV - 2);

  logic [PW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + PW'(1);
    end
  end

  assign tick     = enable && (count == LAST);
  // One cycle of look-ahead lets the step outputs be registered yet still
  // land in the same cycle the count sits at its terminal value.
  assign pre_tick = enable && (count == PRE);

endmodule

// File: rtl/robot_motion_sequencer.sv
// rtl/robot_motion_sequencer.sv - turns front/turn commands into stepper pulse bursts
// Purpose: a forward command becomes FWD_STEPS paired wheel steps, a turn command
//          becomes a right pivot of TURN_STEPS steps; each move is followed by
//          SETTLE_CYC dead cycles. Commands arriving while busy are dropped.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   front  in  forward command (level)
//   turn   in  turn command (level, wins over front)
//   halt   in  abort forward moves / block forward starts (level)
//   step_l out left-wheel step pulse
//   step_r out right-wheel step pulse
//   dir_l  out left-wheel direction, 1 = forward
//   dir_r  out right-wheel direction, 1 = forward
//   busy   out move or settle in progress
//   done   out one-cycle pulse in the first idle cycle after a move
module robot_motion_sequencer
  import robot_pkg::*;
#(
  parameter int STEP_DIV   = STEP_DIV_DEF,
  parameter int FWD_STEPS  = FWD_STEPS_DEF,
  parameter int TURN_STEPS = TURN_STEPS_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic front,
  input  logic turn,
  input  logic halt,
  output logic step_l,
  output logic step_r,
  output logic dir_l,
  output logic dir_r,
  output logic busy,
  output logic done
);

  localparam int SW = $clog2(max_int(FWD_STEPS, TURN_STEPS) + 1);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] FWD_LAST    = SW'(FWD_STEPS - 1);
  localparam logic [SW-1:0] TURN_LAST   = SW'(TURN_STEPS - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  motion_state_t state;
  motion_state_t state_next;

  logic [SW-1:0] step_cnt;
  logic [CW-1:0] settle_cnt;
  logic          turn_move;
  logic          moving;
  logic          entering;
  logic          tick;
  logic          pre_tick;
  logic          step_d;
  logic          dir_r_d;

  assign moving   = (state == FWD) || (state == TURN);
  assign entering = (state_next != state);

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (entering),
    .enable   (moving),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (turn) begin
          state_next = TURN;
        end else if (front && !halt) begin
          state_next = FWD;
        end
      end
      FWD: begin
        if (halt || (tick && (step_cnt == FWD_LAST))) begin
          state_next = SETTLE;
        end
      end
      TURN: begin
        if (tick && (step_cnt == TURN_LAST)) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Step and settle counters restart on every state change.
  always_ff @(posedge clk) begin
    if (rst || entering) begin
      step_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      if (moving && tick) begin
        step_cnt <= step_cnt + SW'(1);
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + CW'(1);
      end
    end
  end

  // Remembers which kind of move the current SETTLE belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_move <= 1'b0;
    end else if ((state == IDLE) && entering) begin
      turn_move <= (state_next == TURN);
    end
  end

  // Output logic: values the output registers take at the next edge
  always_comb begin
    step_d  = 1'b0;
    dir_r_d = 1'b1;
    // A step is only issued if the move survives this edge; a halt or the
    // final step leaving the state suppresses it.
    if (moving && !entering && pre_tick) begin
      step_d = 1'b1;
    end
    if (state_next == TURN) begin
      dir_r_d = 1'b0;
    end else if (state_next == SETTLE) begin
      dir_r_d = !turn_move;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_l <= 1'b0;
      step_r <= 1'b0;
      dir_l  <= 1'b1;
      dir_r  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      step_l <= step_d;
      step_r <= step_d;
      dir_l  <= 1'b1;
      dir_r  <= dir_r_d;
      busy   <= (state_next != IDLE);
      done   <= (state == SETTLE) && (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_robot_motion_sequencer.sv
// tb/tb_robot_motion_sequencer.sv - scoreboard bench for robot_motion_sequencer
`timescale 1ns/1ps
module tb_robot_motion_sequencer;
  import robot_pkg::*;

  localparam int D  = STEP_DIV_DEF;
  localparam int NF = FWD_STEPS_DEF;
  localparam int NT = TURN_STEPS_DEF;
  localparam int SC = SETTLE_CYC_DEF;

  // flags = {busy, done, step_l, step_r, dir_l, dir_r}
  localparam logic [5:0] F_FWD_START = 6'b100011;
  localparam logic [5:0] F_FWD_PULSE = 6'b101111;
  localparam logic [5:0] F_TRN_START = 6'b100010;
  localparam logic [5:0] F_TRN_PULSE = 6'b101110;
  localparam logic [5:0] F_DONE      = 6'b010011;

  typedef struct packed {
    int         cyc;
    logic [5:0] f;
  } ev_t;

  logic clk = 1'b0;
  logic rst, front, turn, halt;
  logic step_l, step_r, dir_l, dir_r, busy, done;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  mon_ev;
  int   cyc  = 0;
  int   vecs = 0;
  int   miss = 0;
  logic prev_busy = 1'b0;

  robot_motion_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .front  (front),
    .turn   (turn),
    .halt   (halt),
    .step_l (step_l),
    .step_r (step_r),
    .dir_l  (dir_l),
    .dir_r  (dir_r),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record busy rises, step pulses and done pulses with their cycle.
  always @(negedge clk) begin
    if ((busy === 1'b1 && prev_busy !== 1'b1) || step_l === 1'b1 ||
        step_r === 1'b1 || done === 1'b1) begin
      mon_ev.cyc = cyc;
      mon_ev.f   = {busy, done, step_l, step_r, dir_l, dir_r};
      obs_q.push_back(mon_ev);
    end
    prev_busy = busy;
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Expected events of one move whose command is sampled by the edge that
  // starts cycle e; done_cyc < 0 means the move never finishes.
  task automatic push_move(input int e, input bit is_turn, input int npulse, input int done_cyc);
    ev_t ev;
    ev.cyc = e;
    ev.f   = is_turn ? F_TRN_START : F_FWD_START;
    exp_q.push_back(ev);
    for (int k = 1; k <= npulse; k++) begin
      ev.cyc = e + k * D - 1;
      ev.f   = is_turn ? F_TRN_PULSE : F_FWD_PULSE;
      exp_q.push_back(ev);
    end
    if (done_cyc >= 0) begin
      ev.cyc = done_cyc;
      ev.f   = F_DONE;
      exp_q.push_back(ev);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; front = 1'b0; turn = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (step_l !== 1'b0) begin miss++; $display("FAIL rst_step_l: got %b expected 0", step_l); end
    vecs++; if (step_r !== 1'b0) begin miss++; $display("FAIL rst_step_r: got %b expected 0", step_r); end
    vecs++; if (dir_l !== 1'b1) begin miss++; $display("FAIL rst_dir_l: got %b expected 1", dir_l); end
    vecs++; if (dir_r !== 1'b1) begin miss++; $display("FAIL rst_dir_r: got %b expected 1", dir_r); end
    vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vecs++; if (done !== 1'b0) begin miss++; $display("FAIL rst_done: got %b expected 0", done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_forward();
    ev_t ee, oo;
    int e;
    exp_q.delete(); obs_q.delete();
    front = 1'b1; e = cyc + 1;
    push_move(e, 1'b0, NF, e + NF * D + SC);
    @(negedge clk); front = 1'b0;
    wait_cycle(e + NF * D + SC + 10);
    while (exp_q.size() != 0) begin
      ee = exp_q.pop_front(); vecs++;
      if (obs_q.size() == 0) begin
        miss++; $display("FAIL fwd_event: got none, expected cyc=%0d flags=%b", ee.cyc, ee.f);
      end else begin
        oo = obs_q.pop_front();
        if (oo !== ee) begin
          miss++; $display("FAIL fwd_event: got cyc=%0d flags=%b, expected cyc=%0d flags=%b", oo.cyc, oo.f, ee.cyc, ee.f);
        end
      end
    end
    vecs++;
    if (obs_q.size() !== 0) begin
      miss++; $display("FAIL fwd_extra: got %0d extra events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
  endtask

  task automatic test_turn_priority();
    ev_t ee, oo;
    int e;
    exp_q.delete(); obs_q.delete();
    front = 1'b1; turn = 1'b1; e = cyc + 1;
    push_move(e, 1'b1, NT, e + NT * D + SC);
    @(negedge clk); front = 1'b0; turn = 1'b0;
    wait_cycle(e + NT * D + SC + 10);
    while (exp_q.size() != 0) begin
      ee = exp_q.pop_front(); vecs++;
      if (obs_q.size() == 0) begin
        miss++; $display("FAIL turn_event: got none, expected cyc=%0d flags=%b", ee.cyc, ee.f);
      end else begin
        oo = obs_q.pop_front();
        if (oo !== ee) begin
          miss++; $display("FAIL turn_event: got cyc=%0d flags=%b, expected cyc=%0d flags=%b", oo.cyc, oo.f, ee.cyc, ee.f);
        end
      end
    end
    vecs++;
    if (obs_q.size() !== 0) begin
      miss++; $display("FAIL turn_extra: got %0d extra events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
  endtask

  task automatic test_halt();
    ev_t ee, oo;
    int e, e2;
    exp_q.delete(); obs_q.delete();
    // Forward move halted in the cycle just before the 4th step would issue.
    front = 1'b1; e = cyc + 1;
    push_move(e, 1'b0, 3, e + 4 * D - 1 + SC);
    @(negedge clk); front = 1'b0;
    wait_cycle(e + 4 * D - 2);
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    wait_cycle(e + 30);
    // halt blocks a forward start from IDLE but a turn still goes through.
    halt = 1'b1; front = 1'b1;
    repeat (6) @(negedge clk);
    turn = 1'b1; e2 = cyc + 1;
    push_move(e2, 1'b1, NT, e2 + NT * D + SC);
    @(negedge clk); turn = 1'b0; front = 1'b0;
    wait_cycle(e2 + NT * D + SC + 8);
    halt = 1'b0;
    while (exp_q.size() != 0) begin
      ee = exp_q.pop_front(); vecs++;
      if (obs_q.size() == 0) begin
        miss++; $display("FAIL halt_event: got none, expected cyc=%0d flags=%b", ee.cyc, ee.f);
      end else begin
        oo = obs_q.pop_front();
        if (oo !== ee) begin
          miss++; $display("FAIL halt_event: got cyc=%0d flags=%b, expected cyc=%0d flags=%b", oo.cyc, oo.f, ee.cyc, ee.f);
        end
      end
    end
    vecs++;
    if (obs_q.size() !== 0) begin
      miss++; $display("FAIL halt_extra: got %0d extra events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
  endtask

  task automatic test_turn_ignored();
    ev_t ee, oo;
    int e;
    int tcyc[4] = '{5, 10, 20, 33};
    exp_q.delete(); obs_q.delete();
    front = 1'b1; e = cyc + 1;
    push_move(e, 1'b0, NF, e + NF * D + SC);
    @(negedge clk); front = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cycle(e + tcyc[i]);
      turn = 1'b1;
      @(negedge clk); turn = 1'b0;
    end
    wait_cycle(e + NF * D + SC + 12);
    while (exp_q.size() != 0) begin
      ee = exp_q.pop_front(); vecs++;
      if (obs_q.size() == 0) begin
        miss++; $display("FAIL ign_event: got none, expected cyc=%0d flags=%b", ee.cyc, ee.f);
      end else begin
        oo = obs_q.pop_front();
        if (oo !== ee) begin
          miss++; $display("FAIL ign_event: got cyc=%0d flags=%b, expected cyc=%0d flags=%b", oo.cyc, oo.f, ee.cyc, ee.f);
        end
      end
    end
    vecs++;
    if (obs_q.size() !== 0) begin
      miss++; $display("FAIL ign_extra: got %0d extra events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
  endtask

  task automatic test_back_to_back();
    ev_t ee, oo;
    int e, len;
    len = NF * D + SC;
    exp_q.delete(); obs_q.delete();
    front = 1'b1; e = cyc + 1;
    for (int m = 0; m < 3; m++) begin
      push_move(e + m * (len + 1), 1'b0, NF, e + m * (len + 1) + len);
    end
    wait_cycle(e + 2 * (len + 1) + 5);
    front = 1'b0;
    wait_cycle(e + 3 * (len + 1) + 10);
    while (exp_q.size() != 0) begin
      ee = exp_q.pop_front(); vecs++;
      if (obs_q.size() == 0) begin
        miss++; $display("FAIL b2b_event: got none, expected cyc=%0d flags=%b", ee.cyc, ee.f);
      end else begin
        oo = obs_q.pop_front();
        if (oo !== ee) begin
          miss++; $display("FAIL b2b_event: got cyc=%0d flags=%b, expected cyc=%0d flags=%b", oo.cyc, oo.f, ee.cyc, ee.f);
        end
      end
    end
    vecs++;
    if (obs_q.size() !== 0) begin
      miss++; $display("FAIL b2b_extra: got %0d extra events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
  endtask

  task automatic test_reset_mid();
    ev_t ee, oo;
    int e;
    exp_q.delete(); obs_q.delete();
    front = 1'b1; e = cyc + 1;
    push_move(e, 1'b0, 5, -1);
    @(negedge clk); front = 1'b0;
    wait_cycle(e + 5 * D - 1);
    rst = 1'b1;
    @(negedge clk);
    vecs++; if (step_l !== 1'b0) begin miss++; $display("FAIL mid_step_l: got %b expected 0", step_l); end
    vecs++; if (step_r !== 1'b0) begin miss++; $display("FAIL mid_step_r: got %b expected 0", step_r); end
    vecs++; if (dir_l !== 1'b1) begin miss++; $display("FAIL mid_dir_l: got %b expected 1", dir_l); end
    vecs++; if (dir_r !== 1'b1) begin miss++; $display("FAIL mid_dir_r: got %b expected 1", dir_r); end
    vecs++; if (busy !== 1'b0) begin miss++; $display("FAIL mid_busy: got %b expected 0", busy); end
    vecs++; if (done !== 1'b0) begin miss++; $display("FAIL mid_done: got %b expected 0", done); end
    rst = 1'b0;
    wait_cycle(e + 5 * D + 25);
    while (exp_q.size() != 0) begin
      ee = exp_q.pop_front(); vecs++;
      if (obs_q.size() == 0) begin
        miss++; $display("FAIL mid_event: got none, expected cyc=%0d flags=%b", ee.cyc, ee.f);
      end else begin
        oo = obs_q.pop_front();
        if (oo !== ee) begin
          miss++; $display("FAIL mid_event: got cyc=%0d flags=%b, expected cyc=%0d flags=%b", oo.cyc, oo.f, ee.cyc, ee.f);
        end
      end
    end
    vecs++;
    if (obs_q.size() !== 0) begin
      miss++; $display("FAIL mid_extra: got %0d extra events (first cyc=%0d), expected 0", obs_q.size(), obs_q[0].cyc);
    end
  endtask

  initial begin
    rst = 1'b1; front = 1'b0; turn = 1'b0; halt = 1'b0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_turn_priority();
    test_halt();
    test_turn_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
